sfq_pulse_deserializer: RTL and testbench
=========================================

Name: sfq_pulse_deserializer

Overview:
- Downstream consumer of the clocked SFQ AND3 gate stage; replaces the ad-hoc print-only sink at the gate output.
- Each clock period it samples one output pulse flag from the gate, packs the bits LSB-first into WORD_W-bit words and buffers the words in a small FIFO.
- Words leave through a valid/ready handshake. Pulse and drop statistics are kept for bench and debug.

Parameters:
- WORD_W, 8, bits per packed output word (2..32).
- DEPTH, 4, FIFO depth in words (power of two, at least 2).
- CNT_W, 16, width of the saturating pulse and drop counters.

Ports:
- clk  in  1  gate clock; the same clock that drives the upstream SFQ gate.
- rst  in  1  asynchronous, active-high reset.
- sample_en  in  1  when high, this cycle's pulse flag is consumed as one bit.
- pulse_in  in  1  1 if the gate emitted an output pulse since the previous clk edge (the interface data flag).
- pulse_clr  out  1  one-cycle strobe, high the cycle after a sampled pulse_in=1; clears the upstream received flag.
- flush  in  1  pushes the partial word, zero-padded in the upper bits.
- word_data  out  WORD_W  FIFO head word.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts the head word when valid and ready are both high.
- pulse_cnt  out  CNT_W  total sampled 1-bits, saturating.
- drop_cnt  out  CNT_W  words discarded because the FIFO was full, saturating.
- overflow  out  1  sticky; set on the first drop, cleared only by rst.

Behaviour:
- Reset (async assert, sync release): shift register=0, bit index=0, FIFO empty, word_valid=0, word_data=0, pulse_clr=0, pulse_cnt=0, drop_cnt=0, overflow=0.
- Sampling: on a clk edge with sample_en=1, bit[idx] is set to pulse_in and idx increments. If pulse_in=1, pulse_cnt increments (holds at all-ones) and pulse_clr=1 in the next cycle only.
- Word completion: when idx reaches WORD_W-1 and a sample occurs, the completed word (including the current bit) is pushed and idx wraps to 0. Latency from the last bit to word_valid is 1 cycle when the FIFO was empty.
- Flush: pushes the current partial word with unfilled bits 0, then idx=0.
  - Flush with idx=0 and no simultaneous sample pushes nothing.
  - Flush together with a sample includes that bit first.
  - Flush in the same cycle as a natural word completion pushes only the completed word.
- FIFO: read pointer, write pointer and count are registered. word_data is driven from the head entry. A pop occurs when word_valid and word_ready are both high.
- Simultaneous push and pop:
  - When full: both succeed, count unchanged, nothing dropped.
  - When empty: the push proceeds, and word_valid rises the next cycle (no bypass).
- Full without pop: the incoming word is dropped, drop_cnt increments (saturating) and overflow=1. FIFO contents are unchanged.
- Pointers wrap modulo DEPTH. The count range is 0..DEPTH.
- word_valid and word_data hold stable while word_ready=0.
- Reset mid-word discards the partial word and all FIFO contents immediately.

Decomposition:
- SFQ_PKG gets constant DESER_WORD_W_DEFAULT and typedef deser_word_t (logic [WORD_W-1:0]).
- One sub-module, sfq_word_fifo: parameterised sync FIFO (DEPTH, WORD_W) with full/empty/count and async active-high reset.
- Packing, flush and counters stay in the top module.

Test Plan:
- Pattern 1,1,0,1,0,0,1,1 on 8 consecutive sampled cycles, word_ready=1 -> word_data=8'hCB, word_valid high for exactly 1 cycle starting 1 cycle after the 8th sample; pulse_cnt=5; pulse_clr strobes 5 times.
- 5 words pushed with word_ready=0, DEPTH=4 -> FIFO holds the first 4 in order, drop_cnt=1, overflow=1. Drain by raising ready -> 4 pops in push order, word_valid falls after the 4th.
- 3 bits 1,0,1 then flush -> word_data=8'h05, idx back to 0. A flush with idx=0 and no sample -> no word pushed.
- FIFO full, ready=1 and a word completing in the same cycle -> no drop; count stays 4; the new word is popped last.
- rst asserted asynchronously mid-word with 2 words queued -> all outputs 0 immediately, before the next clk edge. After release, a fresh 8-bit sequence yields the correct word.
- 2^CNT_W+3 pulses with CNT_W=4 -> pulse_cnt saturates at 4'hF and does not wrap.

Source files
------------

// File: rtl/sfq_pkg.sv
// rtl/sfq_pkg.sv - shared constants and types for the SFQ gate output path
package sfq_pkg;

   localparam int DESER_WORD_W_DEFAULT = 8;

   typedef logic [DESER_WORD_W_DEFAULT-1:0] deser_word_t;

endpackage

// File: rtl/sfq_pulse_deserializer_fifo.sv
// rtl/sfq_pulse_deserializer_fifo.sv - small synchronous word FIFO (sfq_word_fifo)
module sfq_word_fifo #(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 8,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [WORD_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   output logic [WORD_W-1:0] o_rd_data,
   output logic              o_full,
   output logic [CNT_W-1:0]  o_count
);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_rd_ok;
   logic              w_wr_ok;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   // A write into a full FIFO is still accepted when the head leaves in the same cycle.
   assign w_rd_ok = i_rd_en && (r_count != '0);
   assign w_wr_ok = i_wr_en && (!o_full || w_rd_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sfq_pulse_deserializer.sv
// rtl/sfq_pulse_deserializer.sv - packs sampled SFQ gate pulses into buffered words
module sfq_pulse_deserializer
   import sfq_pkg::*;
#(
   parameter int WORD_W = DESER_WORD_W_DEFAULT,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_en,
   input  logic              pulse_in,
   output logic              pulse_clr,
   input  logic              flush,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [CNT_W-1:0]  pulse_cnt,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic              overflow
);

   localparam int IDX_W  = $clog2(WORD_W);
   localparam int FCNT_W = $clog2(DEPTH) + 1;

   logic [WORD_W-1:0] r_shift;
   logic [IDX_W-1:0]  r_idx;
   logic              r_pulse_clr;
   logic [CNT_W-1:0]  r_pulse_cnt;
   logic [CNT_W-1:0]  r_drop_cnt;
   logic              r_overflow;

   logic [WORD_W-1:0] w_cur;
   logic              w_complete;
   logic              w_flush_push;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_drop;
   logic [FCNT_W-1:0] w_count;

   always_comb begin
      w_cur = r_shift;
      if (sample_en) w_cur[r_idx] = pulse_in;
   end

   // A flush coinciding with a natural completion adds nothing beyond the completed word.
   assign w_complete   = sample_en && (r_idx == IDX_W'(WORD_W - 1));
   assign w_flush_push = flush && !w_complete && (sample_en || (r_idx != '0));
   assign w_push       = w_complete || w_flush_push;
   assign w_pop        = word_valid && word_ready;
   assign w_drop       = w_push && w_full && !w_pop;

   sfq_word_fifo #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_push),
      .i_wr_data (w_cur),
      .i_rd_en   (w_pop),
      .o_rd_data (word_data),
      .o_full    (w_full),
      .o_count   (w_count)
   );

   assign word_valid = (w_count != '0);
   assign pulse_clr  = r_pulse_clr;
   assign pulse_cnt  = r_pulse_cnt;
   assign drop_cnt   = r_drop_cnt;
   assign overflow   = r_overflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift     <= '0;
         r_idx       <= '0;
         r_pulse_clr <= 1'b0;
         r_pulse_cnt <= '0;
         r_drop_cnt  <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_push) begin
            r_shift <= '0;
            r_idx   <= '0;
         end else if (sample_en) begin
            r_shift <= w_cur;
            r_idx   <= r_idx + IDX_W'(1);
         end
         r_pulse_clr <= sample_en && pulse_in;
         if (sample_en && pulse_in && (r_pulse_cnt != '1))
            r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sfq_pulse_deserializer.sv
// tb/tb_sfq_pulse_deserializer.sv - directed self-checking bench for sfq_pulse_deserializer
module tb_sfq_pulse_deserializer;
   import sfq_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sample_en = 1'b0;
   logic        pulse_in = 1'b0;
   logic        flush = 1'b0;
   logic        word_ready = 1'b0;

   logic        pulse_clr;
   deser_word_t word_data;
   logic        word_valid;
   logic [15:0] pulse_cnt;
   logic [15:0] drop_cnt;
   logic        overflow;

   logic        s_pulse_clr;
   deser_word_t s_word_data;
   logic        s_word_valid;
   logic [3:0]  s_pulse_cnt;
   logic [3:0]  s_drop_cnt;
   logic        s_overflow;

   int n_checks = 0;
   int n_errors = 0;
   int n_strobes;

   always #5 clk = ~clk;

   sfq_pulse_deserializer #(.WORD_W(8), .DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .pulse_in(pulse_in),
      .pulse_clr(pulse_clr), .flush(flush), .word_data(word_data),
      .word_valid(word_valid), .word_ready(word_ready), .pulse_cnt(pulse_cnt),
      .drop_cnt(drop_cnt), .overflow(overflow)
   );

   sfq_pulse_deserializer #(.WORD_W(8), .DEPTH(4), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .sample_en(sample_en), .pulse_in(pulse_in),
      .pulse_clr(s_pulse_clr), .flush(flush), .word_data(s_word_data),
      .word_valid(s_word_valid), .word_ready(word_ready), .pulse_cnt(s_pulse_cnt),
      .drop_cnt(s_drop_cnt), .overflow(s_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic bit1(input logic b);
      sample_en = 1'b1;
      pulse_in  = b;
      tick();
      sample_en = 1'b0;
      pulse_in  = 1'b0;
   endtask

   task automatic send_bits(input deser_word_t w, input int n);
      for (int i = 0; i < n; i++) bit1(w[i]);
   endtask

   task automatic drain(input deser_word_t e0, input deser_word_t e1,
                        input deser_word_t e2, input deser_word_t e3, input string tag);
      deser_word_t exp_q [4];
      exp_q = '{e0, e1, e2, e3};
      word_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_valid"}, word_valid, 1'b1);
         chk({tag, "_data"}, word_data, exp_q[i]);
         tick();
      end
      word_ready = 1'b0;
      chk({tag, "_empty"}, word_valid, 1'b0);
   endtask

   initial begin
      deser_word_t pat;
      #1 rst = 1'b1;
      tick();
      chk("rst_valid", word_valid, 1'b0);
      chk("rst_data", word_data, 8'h00);
      chk("rst_pclr", pulse_clr, 1'b0);
      chk("rst_pcnt", pulse_cnt, 16'd0);
      chk("rst_dcnt", drop_cnt, 16'd0);
      chk("rst_ovf", overflow, 1'b0);
      rst = 1'b0;

      // pattern 1,1,0,1,0,0,1,1 -> 8'hCB
      word_ready = 1'b1;
      pat = 8'hCB;
      n_strobes = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("p1_not_yet", word_valid, 1'b0);
         bit1(pat[i]);
         chk("p1_pclr", pulse_clr, pat[i]);
         if (pulse_clr) n_strobes++;
      end
      chk("p1_valid", word_valid, 1'b1);
      chk("p1_data", word_data, 8'hCB);
      tick();
      chk("p1_valid_one_cycle", word_valid, 1'b0);
      chk("p1_pclr_idle", pulse_clr, 1'b0);
      chk("p1_pcnt", pulse_cnt, 16'd5);
      chk("p1_strobes", n_strobes, 32'd5);
      word_ready = 1'b0;

      // five words into a four-deep FIFO
      send_bits(8'h11, 8);
      send_bits(8'h22, 8);
      send_bits(8'h33, 8);
      send_bits(8'h44, 8);
      chk("ov_no_drop_yet", drop_cnt, 16'd0);
      send_bits(8'h55, 8);
      chk("ov_dcnt", drop_cnt, 16'd1);
      chk("ov_flag", overflow, 1'b1);
      drain(8'h11, 8'h22, 8'h33, 8'h44, "ov_drain");
      chk("ov_sticky", overflow, 1'b1);

      // partial word flush
      send_bits(8'h05, 3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_valid", word_valid, 1'b1);
      chk("fl_data", word_data, 8'h05);
      word_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      word_ready = 1'b0;
      chk("fl_idle_nopush", word_valid, 1'b0);
      sample_en = 1'b1; pulse_in = 1'b1; flush = 1'b1;
      tick();
      sample_en = 1'b0; pulse_in = 1'b0; flush = 1'b0;
      chk("fl_sample_valid", word_valid, 1'b1);
      chk("fl_sample_data", word_data, 8'h01);
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      chk("fl_sample_pop", word_valid, 1'b0);
      send_bits(8'hFF, 7);
      flush = 1'b1;
      bit1(1'b1);
      flush = 1'b0;
      chk("fl_cmpl_data", word_data, 8'hFF);
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      chk("fl_cmpl_single", word_valid, 1'b0);

      // full FIFO with pop and push in the same cycle
      send_bits(8'h10, 8);
      send_bits(8'h20, 8);
      send_bits(8'h30, 8);
      send_bits(8'h40, 8);
      send_bits(8'h5A, 7);
      word_ready = 1'b1;
      bit1(1'b0);
      word_ready = 1'b0;
      chk("fp_dcnt", drop_cnt, 16'd1);
      drain(8'h20, 8'h30, 8'h40, 8'h5A, "fp_drain");

      // asynchronous reset mid-word with two words queued
      send_bits(8'hAA, 8);
      send_bits(8'h55, 8);
      send_bits(8'h0F, 3);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", word_valid, 1'b0);
      chk("ar_data", word_data, 8'h00);
      chk("ar_pclr", pulse_clr, 1'b0);
      chk("ar_pcnt", pulse_cnt, 16'd0);
      chk("ar_dcnt", drop_cnt, 16'd0);
      chk("ar_ovf", overflow, 1'b0);
      tick();
      rst = 1'b0;
      send_bits(8'h3C, 8);
      chk("ar_fresh_valid", word_valid, 1'b1);
      chk("ar_fresh_data", word_data, 8'h3C);
      chk("ar_fresh_pcnt", pulse_cnt, 16'd4);

      // pulse counter saturation with a 4-bit counter
      rst = 1'b1;
      tick();
      rst = 1'b0;
      word_ready = 1'b1;
      for (int i = 0; i < 15; i++) bit1(1'b1);
      chk("sat_at_15", s_pulse_cnt, 4'hF);
      for (int i = 0; i < 4; i++) bit1(1'b1);
      chk("sat_hold", s_pulse_cnt, 4'hF);
      chk("sat_wide_cnt", pulse_cnt, 16'd19);
      word_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
